// File: rtl/maquina_pkg.sv
// Shared definitions for the digit-entry combination lock.
// Holds the FSM state encodings and the 7-segment patterns.
// Segment patterns are packed as {A,B,C,D,E,F,G}, active high.
package maquina_pkg;

    localparam logic [1:0] ST_ENTRY   = 2'd0;
    localparam logic [1:0] ST_OPEN    = 2'd1;
    localparam logic [1:0] ST_LOCKOUT = 2'd2;

    localparam logic [6:0] SEG_0     = 7'b111_1110;
    localparam logic [6:0] SEG_1     = 7'b011_0000;
    localparam logic [6:0] SEG_2     = 7'b110_1101;
    localparam logic [6:0] SEG_3     = 7'b111_1001;
    localparam logic [6:0] SEG_4     = 7'b011_0011;
    localparam logic [6:0] SEG_5     = 7'b101_1011;
    localparam logic [6:0] SEG_6     = 7'b101_1111;
    localparam logic [6:0] SEG_7     = 7'b111_0000;
    localparam logic [6:0] SEG_8     = 7'b111_1111;
    localparam logic [6:0] SEG_9     = 7'b111_1011;
    localparam logic [6:0] SEG_DASH  = 7'b000_0001;
    localparam logic [6:0] SEG_BLANK = 7'b000_0000;

endpackage

// File: rtl/decodificador_7seg.sv
// Combinational BCD to 7-segment decoder with blank and dash overrides.
// Ports:
//   digito_i : BCD digit (10..15 decode to blank)
//   blank_i  : force all segments off (highest priority)
//   dash_i   : show '-' (segment G only)
//   seg_o    : segments {A,B,C,D,E,F,G}, active high
module decodificador_7seg
    import maquina_pkg::*;
(
    input  logic [3:0] digito_i,
    input  logic       blank_i,
    input  logic       dash_i,
    output logic [6:0] seg_o
);

    // Digit lookup with override priority blank > dash > digit.
    always_comb begin
        seg_o = SEG_BLANK;
        if (blank_i) begin
            seg_o = SEG_BLANK;
        end else if (dash_i) begin
            seg_o = SEG_DASH;
        end else begin
            case (digito_i)
                4'd0:    seg_o = SEG_0;
                4'd1:    seg_o = SEG_1;
                4'd2:    seg_o = SEG_2;
                4'd3:    seg_o = SEG_3;
                4'd4:    seg_o = SEG_4;
                4'd5:    seg_o = SEG_5;
                4'd6:    seg_o = SEG_6;
                4'd7:    seg_o = SEG_7;
                4'd8:    seg_o = SEG_8;
                4'd9:    seg_o = SEG_9;
                default: seg_o = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/maquina_senha_param.sv
// Parametrised digit-entry combination lock.
// Accepts one BCD digit per insere cycle, compares CODE_LEN digits against
// the stored code, opens for a bounded time (during which a new code can be
// programmed) and locks out after MAX_TRIES consecutive wrong codes.
// Ports:
//   clk, reset       : clock, synchronous active-high reset
//   insere, numero   : digit valid strobe and BCD digit (10..15 ignored)
//   programa         : while open, accepted digits program a new code
//   LED              : lock open
//   bloqueado        : lockout active
//   erro             : one-cycle pulse on a wrong complete code
//   A..G             : 7-segment display, active high
// All outputs are registered.
module maquina_senha_param
    import maquina_pkg::*;
#(
    parameter int          CODE_LEN     = 4,
    parameter logic [31:0] DEFAULT_CODE = 32'h0000_5901,
    parameter int          MAX_TRIES    = 3,
    parameter int          OPEN_CYCLES  = 8,
    parameter int          LOCK_CYCLES  = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       insere,
    input  logic [4:1] numero,
    input  logic       programa,
    output logic       LED,
    output logic       bloqueado,
    output logic       erro,
    output logic       A,
    output logic       B,
    output logic       C,
    output logic       D,
    output logic       E,
    output logic       F,
    output logic       G
);

    localparam int IW = $clog2(CODE_LEN);
    localparam int TW = $clog2(((OPEN_CYCLES > LOCK_CYCLES) ? OPEN_CYCLES : LOCK_CYCLES) + 1);
    localparam int CW = 4 * CODE_LEN;

    localparam logic [IW-1:0] LAST_IDX = IW'(CODE_LEN - 1);
    localparam logic [TW-1:0] OPEN_T   = TW'(OPEN_CYCLES);
    localparam logic [TW-1:0] LOCK_T   = TW'(LOCK_CYCLES);
    localparam logic [3:0]    MAX_T    = 4'(MAX_TRIES);

    logic [1:0]    state_q,  state_d;
    logic [IW-1:0] idx_q,    idx_d;
    logic [IW-1:0] pidx_q,   pidx_d;
    logic [3:0]    tries_q,  tries_d;
    logic          mism_q,   mism_d;
    logic [TW-1:0] timer_q,  timer_d;
    logic [CW-1:0] code_q,   code_d;
    logic [CW-1:0] newbuf_q, newbuf_d;
    logic          erro_q,   erro_d;
    logic          led_q,    bloq_q;
    logic [6:0]    seg_q,    seg_d;

    logic          accept_s;
    logic          dig_ne_s;
    logic [3:0]    tries_inc_s;
    logic          disp_load_s;
    logic          disp_blank_s;
    logic          disp_dash_s;
    logic [6:0]    dec_seg_s;

    assign accept_s    = insere && (numero <= 4'd9);
    // {idx,2'b00} is the bit offset of digit idx inside the packed code.
    assign dig_ne_s    = (numero != code_q[{idx_q, 2'b00} +: 4]);
    assign tries_inc_s = (tries_q == 4'hF) ? 4'hF : (tries_q + 4'd1);

    decodificador_7seg u_dec (
        .digito_i (numero),
        .blank_i  (disp_blank_s),
        .dash_i   (disp_dash_s),
        .seg_o    (dec_seg_s)
    );

    // Next-state logic for the lock FSM, counters, code registers and display.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        pidx_d       = pidx_q;
        tries_d      = tries_q;
        mism_d       = mism_q;
        timer_d      = timer_q;
        code_d       = code_q;
        newbuf_d     = newbuf_q;
        erro_d       = 1'b0;
        disp_load_s  = 1'b0;
        disp_blank_s = 1'b0;
        disp_dash_s  = 1'b0;
        case (state_q)
            ST_ENTRY: begin
                if (accept_s) begin
                    disp_load_s = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        idx_d  = '0;
                        mism_d = 1'b0;
                        if (!(mism_q || dig_ne_s)) begin
                            state_d = ST_OPEN;
                            tries_d = 4'd0;
                            timer_d = OPEN_T;
                        end else begin
                            erro_d  = 1'b1;
                            tries_d = tries_inc_s;
                            if (tries_inc_s == MAX_T) begin
                                state_d     = ST_LOCKOUT;
                                timer_d     = LOCK_T;
                                disp_dash_s = 1'b1;
                            end else begin
                                state_d = ST_ENTRY;
                            end
                        end
                    end else begin
                        idx_d  = idx_q + 1'b1;
                        mism_d = mism_q | dig_ne_s;
                    end
                end else begin
                    state_d = ST_ENTRY;
                end
            end
            ST_OPEN: begin
                if (accept_s && programa) begin
                    // A programming digit reloads the timer, so it always beats expiry.
                    disp_load_s = 1'b1;
                    timer_d     = OPEN_T;
                    newbuf_d[{pidx_q, 2'b00} +: 4] = numero;
                    if (pidx_q == LAST_IDX) begin
                        code_d       = newbuf_d;
                        pidx_d       = '0;
                        state_d      = ST_ENTRY;
                        timer_d      = '0;
                        disp_blank_s = 1'b1;
                    end else begin
                        pidx_d = pidx_q + 1'b1;
                    end
                end else if (accept_s) begin
                    // Plain digit while open relocks; it is not part of an entry.
                    disp_load_s  = 1'b1;
                    disp_blank_s = 1'b1;
                    pidx_d       = '0;
                    state_d      = ST_ENTRY;
                    timer_d      = '0;
                end else if (timer_q <= TW'(1)) begin
                    disp_load_s  = 1'b1;
                    disp_blank_s = 1'b1;
                    pidx_d       = '0;
                    state_d      = ST_ENTRY;
                    timer_d      = '0;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            ST_LOCKOUT: begin
                if (timer_q <= TW'(1)) begin
                    disp_load_s  = 1'b1;
                    disp_blank_s = 1'b1;
                    tries_d      = 4'd0;
                    state_d      = ST_ENTRY;
                    timer_d      = '0;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: begin
                state_d      = ST_ENTRY;
                idx_d        = '0;
                pidx_d       = '0;
                mism_d       = 1'b0;
                timer_d      = '0;
                disp_load_s  = 1'b1;
                disp_blank_s = 1'b1;
            end
        endcase
        if (disp_load_s) begin
            seg_d = dec_seg_s;
        end else begin
            seg_d = seg_q;
        end
    end

    // State and output registers; outputs follow the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_ENTRY;
            idx_q    <= '0;
            pidx_q   <= '0;
            tries_q  <= 4'd0;
            mism_q   <= 1'b0;
            timer_q  <= '0;
            code_q   <= DEFAULT_CODE[CW-1:0];
            newbuf_q <= '0;
            erro_q   <= 1'b0;
            led_q    <= 1'b0;
            bloq_q   <= 1'b0;
            seg_q    <= SEG_BLANK;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            pidx_q   <= pidx_d;
            tries_q  <= tries_d;
            mism_q   <= mism_d;
            timer_q  <= timer_d;
            code_q   <= code_d;
            newbuf_q <= newbuf_d;
            erro_q   <= erro_d;
            led_q    <= (state_d == ST_OPEN);
            bloq_q   <= (state_d == ST_LOCKOUT);
            seg_q    <= seg_d;
        end
    end

    assign LED       = led_q;
    assign bloqueado = bloq_q;
    assign erro      = erro_q;
    assign {A, B, C, D, E, F, G} = seg_q;

endmodule

// File: tb/tb_maquina_senha_param.sv
module tb_maquina_senha_param;

    localparam int          CODE_LEN    = 4;
    localparam logic [31:0] DEF_CODE    = 32'h0000_5901;
    localparam int          MAX_TRIES   = 3;
    localparam int          OPEN_CYCLES = 8;
    localparam int          LOCK_CYCLES = 16;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic insere = 1'b0;
    logic [4:1] numero = 4'd0;
    logic programa = 1'b0;
    logic LED, bloqueado, erro, A, B, C, D, E, F, G;
    logic [6:0] seg;

    assign seg = {A, B, C, D, E, F, G};

    always #5 clk = ~clk;

    maquina_senha_param #(
        .CODE_LEN(CODE_LEN), .DEFAULT_CODE(DEF_CODE), .MAX_TRIES(MAX_TRIES),
        .OPEN_CYCLES(OPEN_CYCLES), .LOCK_CYCLES(LOCK_CYCLES)
    ) dut (
        .clk(clk), .reset(reset), .insere(insere), .numero(numero), .programa(programa),
        .LED(LED), .bloqueado(bloqueado), .erro(erro),
        .A(A), .B(B), .C(C), .D(D), .E(E), .F(F), .G(G)
    );

    int total = 0;
    int bad = 0;
    int erro_seen = 0;

    // ---------------- reference model (sequence level) ----------------
    int   m_code[CODE_LEN];
    int   m_entry[$];
    int   m_prog[$];
    int   m_tries;
    int   m_open_left;
    int   m_lock_left;
    logic m_led, m_blk, m_erro;
    logic [6:0] m_seg;
    string seg_names[10] = '{"ABCDEF", "BC", "ABDEG", "ABCDG", "BCFG",
                             "ACDFG", "ACDEFG", "ABC", "ABCDEFG", "ABCDFG"};

    function automatic logic [6:0] seg_from(input string s);
        logic [6:0] r = 7'd0;
        for (int i = 0; i < s.len(); i++) r[6 - (s[i] - "A")] = 1'b1;
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < CODE_LEN; i++) m_code[i] = int'((DEF_CODE >> (4 * i)) & 32'hF);
        m_entry.delete(); m_prog.delete();
        m_tries = 0; m_open_left = 0; m_lock_left = 0;
        m_seg = 7'd0; m_erro = 1'b0; m_led = 1'b0; m_blk = 1'b0;
    endtask

    task automatic model_step(input logic r, input logic ins, input int num, input logic prog);
        bit acc, ok;
        if (r) begin
            model_reset();
            return;
        end
        m_erro = 1'b0;
        acc = ins && (num <= 9);
        if (m_lock_left > 0) begin
            m_lock_left--;
            if (m_lock_left == 0) begin m_tries = 0; m_seg = 7'd0; end
        end else if (m_open_left > 0) begin
            if (acc && prog) begin
                m_prog.push_back(num);
                m_seg = seg_from(seg_names[num]);
                m_open_left = OPEN_CYCLES;
                if (m_prog.size() == CODE_LEN) begin
                    for (int i = 0; i < CODE_LEN; i++) m_code[i] = m_prog[i];
                    m_prog.delete(); m_open_left = 0; m_seg = 7'd0;
                end
            end else if (acc) begin
                m_open_left = 0; m_prog.delete(); m_seg = 7'd0;
            end else begin
                m_open_left--;
                if (m_open_left == 0) begin m_prog.delete(); m_seg = 7'd0; end
            end
        end else if (acc) begin
            m_entry.push_back(num);
            m_seg = seg_from(seg_names[num]);
            if (m_entry.size() == CODE_LEN) begin
                ok = 1'b1;
                for (int i = 0; i < CODE_LEN; i++) if (m_entry[i] != m_code[i]) ok = 1'b0;
                m_entry.delete();
                if (ok) begin
                    m_open_left = OPEN_CYCLES; m_tries = 0;
                end else begin
                    m_erro = 1'b1; m_tries++;
                    if (m_tries == MAX_TRIES) begin m_lock_left = LOCK_CYCLES; m_seg = seg_from("G"); end
                end
            end
        end
        m_led = (m_open_left > 0);
        m_blk = (m_lock_left > 0);
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(input string nm, input logic [6:0] act, input logic [6:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @%0t: got %b want %b", nm, $time, act, exp);
        end
    endtask

    task automatic cycle(input logic r, input logic ins, input logic [3:0] num, input logic prog,
                         input bit use_model);
        reset = r; insere = ins; numero = num; programa = prog;
        @(posedge clk);
        model_step(r, ins, int'(num), prog);
        #1;
        if (erro === 1'b1) erro_seen++;
        if (use_model) begin
            chk("model_led",  {6'd0, LED},       {6'd0, m_led});
            chk("model_blk",  {6'd0, bloqueado}, {6'd0, m_blk});
            chk("model_erro", {6'd0, erro},      {6'd0, m_erro});
            chk("model_seg",  seg,               m_seg);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
    endtask

    task automatic enter4(input logic [15:0] digs, input logic prog);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, digs[15 - 4 * i -: 4], prog, 1'b1);
    endtask

    typedef struct {
        logic       rst;
        logic       ins;
        logic [3:0] num;
        logic       prog;
        logic       led;
        logic       blk;
        logic       err;
        logic [6:0] sg;
    } vec_t;

    vec_t vecs[19];

    initial begin
        vec_t v;
        model_reset();

        // ---------------- table-driven vectors ----------------
        vecs[0]  = '{1'b1, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 7'b000_0000};
        vecs[1]  = '{1'b0, 1'b1, 4'd1,  1'b0, 1'b0, 1'b0, 1'b0, 7'b011_0000};
        vecs[2]  = '{1'b0, 1'b1, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 7'b111_1110};
        vecs[3]  = '{1'b0, 1'b1, 4'd9,  1'b0, 1'b0, 1'b0, 1'b0, 7'b111_1011};
        vecs[4]  = '{1'b0, 1'b1, 4'd5,  1'b0, 1'b1, 1'b0, 1'b0, 7'b101_1011};
        vecs[5]  = '{1'b0, 1'b0, 4'd0,  1'b0, 1'b1, 1'b0, 1'b0, 7'b101_1011};
        vecs[6]  = '{1'b1, 1'b1, 4'd3,  1'b0, 1'b0, 1'b0, 1'b0, 7'b000_0000};
        vecs[7]  = '{1'b0, 1'b1, 4'd1,  1'b0, 1'b0, 1'b0, 1'b0, 7'b011_0000};
        vecs[8]  = '{1'b0, 1'b1, 4'hA,  1'b0, 1'b0, 1'b0, 1'b0, 7'b011_0000};
        vecs[9]  = '{1'b0, 1'b1, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 7'b111_1110};
        vecs[10] = '{1'b0, 1'b1, 4'hF,  1'b0, 1'b0, 1'b0, 1'b0, 7'b111_1110};
        vecs[11] = '{1'b0, 1'b1, 4'd9,  1'b0, 1'b0, 1'b0, 1'b0, 7'b111_1011};
        vecs[12] = '{1'b0, 1'b1, 4'd4,  1'b0, 1'b0, 1'b0, 1'b1, 7'b011_0011};
        vecs[13] = '{1'b0, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 7'b011_0011};
        vecs[14] = '{1'b0, 1'b1, 4'd1,  1'b0, 1'b0, 1'b0, 1'b0, 7'b011_0000};
        vecs[15] = '{1'b0, 1'b1, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 7'b111_1110};
        vecs[16] = '{1'b0, 1'b1, 4'd9,  1'b0, 1'b0, 1'b0, 1'b0, 7'b111_1011};
        vecs[17] = '{1'b0, 1'b1, 4'd5,  1'b0, 1'b1, 1'b0, 1'b0, 7'b101_1011};
        vecs[18] = '{1'b0, 1'b1, 4'd7,  1'b0, 1'b0, 1'b0, 1'b0, 7'b000_0000};

        for (int i = 0; i < 19; i++) begin
            v = vecs[i];
            cycle(v.rst, v.ins, v.num, v.prog, 1'b0);
            chk($sformatf("vec%0d_led", i),  {6'd0, LED},       {6'd0, v.led});
            chk($sformatf("vec%0d_blk", i),  {6'd0, bloqueado}, {6'd0, v.blk});
            chk($sformatf("vec%0d_erro", i), {6'd0, erro},      {6'd0, v.err});
            chk($sformatf("vec%0d_seg", i),  seg,               v.sg);
        end

        // ---------------- open timeout: LED high exactly 8 cycles ----------------
        cycle(1'b1, 1'b0, 4'd0, 1'b0, 1'b1);
        enter4(16'h1095, 1'b0);
        idle(7);
        chk("open_still_led", {6'd0, LED}, 7'd1);
        idle(1);
        chk("open_timeout_led", {6'd0, LED}, 7'd0);
        chk("open_timeout_seg", seg, 7'd0);

        // ---------------- three wrong codes -> lockout ----------------
        erro_seen = 0;
        enter4(16'h1094, 1'b0);
        enter4(16'h1094, 1'b0);
        enter4(16'h1094, 1'b0);
        chk("erro_pulses", 7'(erro_seen), 7'd3);
        chk("lock_blk", {6'd0, bloqueado}, 7'd1);
        chk("lock_dash", seg, 7'b000_0001);
        for (int i = 0; i < 15; i++) cycle(1'b0, 1'b1, 4'(i % 10), 1'b0, 1'b1);
        chk("lock_hold_blk", {6'd0, bloqueado}, 7'd1);
        chk("lock_hold_dash", seg, 7'b000_0001);
        cycle(1'b0, 1'b1, 4'd1, 1'b0, 1'b1);
        chk("lock_end_blk", {6'd0, bloqueado}, 7'd0);
        chk("lock_end_seg", seg, 7'd0);
        enter4(16'h1095, 1'b0);
        chk("after_lock_open", {6'd0, LED}, 7'd1);

        // ---------------- programming a new code ----------------
        cycle(1'b1, 1'b0, 4'd0, 1'b0, 1'b1);
        enter4(16'h1095, 1'b0);
        enter4(16'h2233, 1'b1);
        chk("prog_relock", {6'd0, LED}, 7'd0);
        erro_seen = 0;
        enter4(16'h1095, 1'b0);
        chk("old_code_rejected", 7'(erro_seen), 7'd1);
        enter4(16'h2233, 1'b0);
        chk("new_code_opens", {6'd0, LED}, 7'd1);
        cycle(1'b1, 1'b0, 4'd0, 1'b0, 1'b1);
        enter4(16'h1095, 1'b0);
        chk("reset_restores_default", {6'd0, LED}, 7'd1);

        // ---------------- relock by plain digit ----------------
        cycle(1'b0, 1'b1, 4'd7, 1'b0, 1'b1);
        chk("relock_led", {6'd0, LED}, 7'd0);

        // ---------------- partial programming then timeout ----------------
        enter4(16'h1095, 1'b0);
        cycle(1'b0, 1'b1, 4'd2, 1'b1, 1'b1);
        cycle(1'b0, 1'b1, 4'd2, 1'b1, 1'b1);
        idle(8);
        chk("partial_timeout_led", {6'd0, LED}, 7'd0);
        enter4(16'h1095, 1'b0);
        chk("partial_old_code", {6'd0, LED}, 7'd1);

        // ---------------- completing digit on the expiry cycle ----------------
        cycle(1'b0, 1'b1, 4'd6, 1'b1, 1'b1);
        cycle(1'b0, 1'b1, 4'd7, 1'b1, 1'b1);
        cycle(1'b0, 1'b1, 4'd8, 1'b1, 1'b1);
        idle(7);
        chk("edge_still_open", {6'd0, LED}, 7'd1);
        cycle(1'b0, 1'b1, 4'd1, 1'b1, 1'b1);
        enter4(16'h6781, 1'b0);
        chk("edge_prog_wins", {6'd0, LED}, 7'd1);

        // ---------------- reset mid-entry and during lockout ----------------
        cycle(1'b1, 1'b0, 4'd0, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 4'd1, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 4'd0, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 4'd9, 1'b0, 1'b1);
        chk("rst_mid_seg", seg, 7'd0);
        enter4(16'h1095, 1'b0);
        chk("rst_mid_open", {6'd0, LED}, 7'd1);
        cycle(1'b1, 1'b0, 4'd0, 1'b0, 1'b1);
        enter4(16'h0000, 1'b0);
        enter4(16'h0000, 1'b0);
        enter4(16'h0000, 1'b0);
        idle(2);
        cycle(1'b1, 1'b0, 4'd0, 1'b0, 1'b1);
        chk("rst_lock_blk", {6'd0, bloqueado}, 7'd0);
        chk("rst_lock_seg", seg, 7'd0);
        enter4(16'h1095, 1'b0);
        chk("rst_lock_open", {6'd0, LED}, 7'd1);

        // ---------------- randomized run against the model ----------------
        cycle(1'b1, 1'b0, 4'd0, 1'b0, 1'b1);
        for (int n = 0; n < 4000; n++) begin
            logic r, ins, prog;
            logic [3:0] num;
            r    = ($urandom_range(0, 299) == 0);
            ins  = ($urandom_range(0, 99) < 60);
            prog = ($urandom_range(0, 99) < 60);
            if ($urandom_range(0, 99) < 70 && m_open_left == 0)
                num = 4'(m_code[m_entry.size() % CODE_LEN]);
            else
                num = 4'($urandom_range(0, 15));
            cycle(r, ins, num, prog, 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/maquina_senha_param.md
Name: maquina_senha_param

Overview:
Parametrised successor of the single-code entry machine. It is a digit-entry combination lock that accepts one BCD digit per `insere` cycle and compares the sequence against a stored code of CODE_LEN digits. On a match it opens (LED) for a bounded time, during which a new code can be programmed. After MAX_TRIES wrong codes it locks out. It drives a 7-segment display (A–G) and sits at the top of the lab board, between the switch/button inputs and the LED/display outputs.

Parameters:
- CODE_LEN, 4: digits per code (2..8).
- DEFAULT_CODE, 32'h0000_5901: code loaded at reset. Low CODE_LEN nibbles are used; digit 0 is the least-significant nibble and is entered first.
- MAX_TRIES, 3: consecutive wrong codes before lockout (1..15).
- OPEN_CYCLES, 8: cycles that LED stays high without programming activity.
- LOCK_CYCLES, 16: lockout duration in cycles.

Ports:
- clk, in, 1: single clock; all state changes on the rising edge.
- reset, in, 1: synchronous, active-high reset.
- insere, in, 1: digit-valid; `numero` is sampled on every rising edge where `insere`=1.
- numero, in, 4 ([4:1]): BCD digit; values 10..15 are invalid.
- programa, in, 1: in OPEN, accepted digits go to the new-code buffer.
- LED, out, 1: lock open.
- bloqueado, out, 1: lockout active.
- erro, out, 1: one-cycle pulse on a wrong complete code.
- A, B, C, D, E, F, G, out, 1 each: active-high segments.

Behaviour:
- Clock and reset: one clock `clk`. Reset is synchronous, active-high, sampled on the rising edge of `clk`.
- Reset values: state=ENTRY, idx=0, tries=0, mismatch=0, code=DEFAULT_CODE, LED=0, bloqueado=0, erro=0, display blank (A..G=0). Reset has priority over every event, including mid-entry, OPEN and LOCKOUT.
- Outputs are registered. Each takes effect the cycle after the sampling edge.
- Digit acceptance: `insere`=1 and `numero`<=9. Invalid digits are ignored entirely: no idx advance, no display change.
- Display:
  - Shows the last accepted digit.
  - Encodings: 0=ABCDEF, 1=BC, 2=ABDEG, 3=ABCDG, 4=BCFG, 5=ACDFG, 6=ACDEFG, 7=ABC, 8=ABCDEFG, 9=ABCDFG.
  - LOCKOUT shows '-' (G only).
  - Entering ENTRY from OPEN or LOCKOUT blanks the display.
- State ENTRY:
  - Accepted digit: mismatch |= (numero != code digit[idx]).
  - idx<CODE_LEN-1: idx++.
  - idx==CODE_LEN-1: idx→0 and mismatch→0, then one of:
    - Final mismatch=0 → OPEN, tries→0, timer→OPEN_CYCLES.
    - Otherwise erro pulses for 1 cycle and tries++.
    - If tries+1==MAX_TRIES → LOCKOUT, timer→LOCK_CYCLES. Otherwise stay in ENTRY.
  - Latency: LED=1 on the cycle after the edge that samples the last correct digit.
- State OPEN:
  - LED=1.
  - Timer decrements each cycle. It reloads to OPEN_CYCLES on every accepted digit with `programa`=1.
  - Accepted digit with `programa`=1 is written to newbuf[pidx], then pidx++. After the CODE_LEN-th digit: code←newbuf, pidx→0, → ENTRY.
  - Accepted digit with `programa`=0 → ENTRY immediately (relock); the digit is not counted as entry.
  - Timer reaching 0 → ENTRY. A partially programmed buffer is discarded and `code` is unchanged.
  - Timer expiry and a completing programming digit in the same cycle: programming wins (code updated).
- State LOCKOUT:
  - bloqueado=1; `insere` is ignored.
  - Timer reaching 0 → ENTRY, tries→0, bloqueado→0.
- Width rules:
  - tries: 4 bits, saturating.
  - Timers: $clog2(max(OPEN_CYCLES, LOCK_CYCLES)+1) bits.
  - idx and pidx: $clog2(CODE_LEN) bits, never exceeding CODE_LEN-1.

Decomposition:
- Package maquina_pkg: state enum (ENTRY, OPEN, LOCKOUT), segment constants SEG_0..SEG_9, SEG_DASH, SEG_BLANK.
- One combinational sub-module, decodificador_7seg: 4-bit digit plus blank and dash controls in, A..G out.
- FSM, counters and code registers stay in maquina_senha_param.

Test Plan:
- Correct code: reset, then insere digits 1,0,9,5 on consecutive cycles → LED=1 on the cycle after the 5 is sampled; display shows 5 (ACDFG); LED=0 after 8 cycles with no input.
- Wrong codes: enter 1,0,9,4 three times → erro pulses 3 times; bloqueado=1 after the third; display shows G only. Inputs during the 16 lockout cycles → no effect. Then bloqueado=0.
- Invalid digits: enter 1, 4'b1010, 0, 4'b1111, 9, 5 → treated as 1,0,9,5 → LED=1; display never changes on the invalid cycles.
- Programming: open with 1,0,9,5; with programa=1 enter 2,2,3,3 → return to ENTRY. Then 1,0,9,5 → erro=1, and 2,2,3,3 → LED=1.
- Reset mid-operation: reset asserted after 2 digits, or during LOCKOUT → all outputs at reset values next cycle; DEFAULT_CODE 1,0,9,5 opens again.
- Relock and programming timeout: in OPEN, digit 7 with programa=0 → LED=0 next cycle. Separately, in OPEN enter 2,2 with programa=1 and then stay idle → timeout; old code 1,0,9,5 still opens.
